// File: rtl/control_sequencer_pkg.sv
// Shared types for the VeriRISC sequencer: opcode and phase encodings plus ALU-class decode.
package control_sequencer_pkg;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  function automatic logic is_aluop(opcode_t op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath bundle. The step input exists only when CONTROL_STEP_EN is defined.
interface control_sequencer_if;
  import control_sequencer_pkg::*;

  opcode_t opcode;
  logic    zero;
`ifdef CONTROL_STEP_EN
  logic    step;
`endif
  logic    mem_rd;
  logic    mem_wr;
  logic    load_ir;
  logic    inc_pc;
  logic    load_pc;
  logic    load_ac;
  logic    data_e;
  logic    halt;
  phase_t  phase;

  modport master (
`ifdef CONTROL_STEP_EN
    input  step,
`endif
    input  opcode, zero,
    output mem_rd, mem_wr, load_ir, inc_pc, load_pc, load_ac, data_e, halt, phase
  );

  modport slave (
`ifdef CONTROL_STEP_EN
    output step,
`endif
    output opcode, zero,
    input  mem_rd, mem_wr, load_ir, inc_pc, load_pc, load_ac, data_e, halt, phase
  );

endinterface

// File: rtl/control_sequencer.sv
// Eight-phase VeriRISC instruction sequencer: phase register plus combinational strobe decode.
// CONTROL_STEP_EN: when defined, INST_ADDR waits for a step pulse before each instruction.
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  control_sequencer_if.master bus
);

  phase_t phase_q, phase_d;
  logic   alu_op;
  logic   mem_rd, mem_wr, load_ir, inc_pc, load_pc, load_ac, data_e, halt;

  assign alu_op = is_aluop(bus.opcode);

  always_comb begin
    phase_d = phase_t'(phase_q + 3'd1);
    // HLT parks the sequencer in OP_ADDR; only reset releases it.
    if (phase_q == OP_ADDR && bus.opcode == HLT) phase_d = OP_ADDR;
`ifdef CONTROL_STEP_EN
    if (phase_q == INST_ADDR && !bus.step) phase_d = INST_ADDR;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) phase_q <= INST_ADDR;
    else     phase_q <= phase_d;
  end

  always_comb begin
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    load_ir = 1'b0;
    inc_pc  = 1'b0;
    load_pc = 1'b0;
    load_ac = 1'b0;
    data_e  = 1'b0;
    halt    = 1'b0;
    case (phase_q)
      INST_FETCH: mem_rd = 1'b1;
      INST_LOAD, IDLE: begin
        mem_rd  = 1'b1;
        load_ir = 1'b1;
      end
      OP_ADDR: begin
        halt   = (bus.opcode == HLT);
        inc_pc = (bus.opcode != HLT);
      end
      OP_FETCH: mem_rd = alu_op;
      ALU_OP: begin
        mem_rd  = alu_op;
        load_ac = alu_op;
        inc_pc  = (bus.opcode == SKZ) && bus.zero;
        load_pc = (bus.opcode == JMP);
        data_e  = (bus.opcode == STO);
      end
      STORE: begin
        mem_rd  = alu_op;
        load_ac = alu_op;
        load_pc = (bus.opcode == JMP);
        mem_wr  = (bus.opcode == STO);
        data_e  = (bus.opcode == STO);
      end
      default: ;
    endcase
  end

  assign bus.mem_rd  = mem_rd;
  assign bus.mem_wr  = mem_wr;
  assign bus.load_ir = load_ir;
  assign bus.inc_pc  = inc_pc;
  assign bus.load_pc = load_pc;
  assign bus.load_ac = load_ac;
  assign bus.data_e  = data_e;
  assign bus.halt    = halt;
  assign bus.phase   = phase_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized self-checking bench for control_sequencer against a phase/strobe-table model.
module tb_control_sequencer;
  import control_sequencer_pkg::*;

`ifdef CONTROL_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   exp_ph = 0;

  control_sequencer_if bus ();

  control_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Strobe vector order: mem_rd mem_wr load_ir inc_pc load_pc load_ac data_e halt
  function automatic logic [7:0] model_outs(int ph, opcode_t op, logic z);
    bit alu;
    bit rd, wr, ir, ipc, lpc, lac, de, h;
    alu = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    rd  = (ph >= 1 && ph <= 3) || (alu && ph >= 5);
    wr  = (op == STO) && (ph == 7);
    ir  = (ph == 2) || (ph == 3);
    ipc = (ph == 4 && op != HLT) || (ph == 6 && op == SKZ && z);
    lpc = (op == JMP) && (ph == 6 || ph == 7);
    lac = alu && (ph == 6 || ph == 7);
    de  = (op == STO) && (ph == 6 || ph == 7);
    h   = (ph == 4) && (op == HLT);
    return {rd, wr, ir, ipc, lpc, lac, de, h};
  endfunction

  function automatic int model_next(int ph, opcode_t op, bit s);
    if (ph == 4 && op == HLT) return 4;
    if (STEP_EN && ph == 0 && !s) return 0;
    return (ph + 1) % 8;
  endfunction

  function automatic logic [7:0] dut_outs();
    return {bus.mem_rd, bus.mem_wr, bus.load_ir, bus.inc_pc,
            bus.load_pc, bus.load_ac, bus.data_e, bus.halt};
  endfunction

  // Drive inputs at the negedge, advance the model at the posedge, return at the next negedge.
  task automatic tick(input bit r, input opcode_t op, input bit z, input bit s);
    rst        = r;
    bus.opcode = op;
    bus.zero   = z;
`ifdef CONTROL_STEP_EN
    bus.step   = s;
`endif
    @(posedge clk);
    exp_ph = r ? 0 : model_next(exp_ph, op, s);
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick(1'b1, LDA, 1'b1, 1'b1);
    tick(1'b1, STO, 1'b0, 1'b1);
    checks++;
    if (bus.phase !== INST_ADDR) begin
      errors++;
      $display("FAIL reset_phase got %0d want 0", bus.phase);
    end
    checks++;
    if (dut_outs() !== 8'h00) begin
      errors++;
      $display("FAIL reset_outs got %b want 00000000", dut_outs());
    end
  endtask

  task automatic test_instructions();
    opcode_t ops [5] = '{LDA, STO, SKZ, SKZ, JMP};
    bit      zs  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 5; k++) begin
      tick(1'b1, ops[k], zs[k], 1'b0);
      for (int c = 0; c < 8; c++) begin
        tick(1'b0, ops[k], zs[k], c == 0);
        checks++;
        if (bus.phase !== 3'((c + 1) % 8)) begin
          errors++;
          $display("FAIL instr_phase op=%0d cyc=%0d got %0d want %0d",
                   ops[k], c, bus.phase, (c + 1) % 8);
        end
        checks++;
        if (dut_outs() !== model_outs(exp_ph, ops[k], zs[k])) begin
          errors++;
          $display("FAIL instr_outs op=%0d z=%0d ph=%0d got %b want %b",
                   ops[k], zs[k], exp_ph, dut_outs(), model_outs(exp_ph, ops[k], zs[k]));
        end
      end
    end
  endtask

  task automatic test_halt();
    tick(1'b1, HLT, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) tick(1'b0, HLT, 1'b0, 1'b1);
    for (int c = 0; c < 22; c++) begin
      checks++;
      if (bus.phase !== OP_ADDR || bus.halt !== 1'b1 || bus.inc_pc !== 1'b0) begin
        errors++;
        $display("FAIL halt_stall cyc=%0d got ph=%0d halt=%b inc=%b want ph=4 halt=1 inc=0",
                 c, bus.phase, bus.halt, bus.inc_pc);
      end
      tick(1'b0, HLT, 1'(c), 1'b1);
    end
    tick(1'b1, HLT, 1'b0, 1'b1);
    checks++;
    if (bus.phase !== INST_ADDR || dut_outs() !== 8'h00) begin
      errors++;
      $display("FAIL halt_reset got ph=%0d outs=%b want ph=0 outs=00000000",
               bus.phase, dut_outs());
    end
  endtask

  task automatic test_reset_mid();
    tick(1'b1, ADD, 1'b0, 1'b1);
    for (int c = 0; c < 6; c++) tick(1'b0, ADD, 1'b0, 1'b1);
    checks++;
    if (bus.phase !== ALU_OP || bus.load_ac !== 1'b1) begin
      errors++;
      $display("FAIL mid_reach got ph=%0d load_ac=%b want ph=6 load_ac=1", bus.phase, bus.load_ac);
    end
    tick(1'b1, ADD, 1'b0, 1'b1);
    checks++;
    if (bus.phase !== INST_ADDR || dut_outs() !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset got ph=%0d outs=%b want ph=0 outs=00000000",
               bus.phase, dut_outs());
    end
  endtask

`ifdef CONTROL_STEP_EN
  task automatic test_step();
    tick(1'b1, LDA, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      tick(1'b0, LDA, 1'b0, 1'b0);
      checks++;
      if (bus.phase !== INST_ADDR || dut_outs() !== 8'h00) begin
        errors++;
        $display("FAIL step_wait cyc=%0d got ph=%0d outs=%b want ph=0 outs=0", c, bus.phase, dut_outs());
      end
    end
    tick(1'b0, LDA, 1'b0, 1'b1);
    for (int c = 0; c < 7; c++) tick(1'b0, LDA, 1'b0, 1'($urandom_range(0, 1)));
    checks++;
    if (bus.phase !== INST_ADDR) begin
      errors++;
      $display("FAIL step_pass got ph=%0d want 0", bus.phase);
    end
    for (int c = 0; c < 5; c++) tick(1'b0, LDA, 1'b0, 1'b0);
    checks++;
    if (bus.phase !== INST_ADDR) begin
      errors++;
      $display("FAIL step_rewait got ph=%0d want 0", bus.phase);
    end
  endtask
`endif

  task automatic test_random();
    opcode_t op = LDA;
    bit      r, z, s;
    tick(1'b1, op, 1'b0, 1'b0);
    for (int c = 0; c < 400; c++) begin
      if (exp_ph == 0) op = opcode_t'($urandom_range(0, 7));
      r = ($urandom_range(0, 39) == 0);
      z = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      tick(r, op, z, s);
      checks++;
      if (bus.phase !== 3'(exp_ph)) begin
        errors++;
        $display("FAIL rand_phase cyc=%0d got %0d want %0d", c, bus.phase, exp_ph);
      end
      checks++;
      if (dut_outs() !== model_outs(exp_ph, op, z)) begin
        errors++;
        $display("FAIL rand_outs cyc=%0d op=%0d ph=%0d got %b want %b",
                 c, op, exp_ph, dut_outs(), model_outs(exp_ph, op, z));
      end
      checks++;
      if ((bus.inc_pc && bus.load_pc) || (bus.mem_rd && bus.mem_wr)) begin
        errors++;
        $display("FAIL rand_exclusive cyc=%0d got %b want no conflict", c, dut_outs());
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    bus.opcode = HLT;
    bus.zero   = 1'b0;
`ifdef CONTROL_STEP_EN
    bus.step   = 1'b0;
`endif
    @(negedge clk);
    test_reset();
    test_instructions();
    test_halt();
    test_reset_mid();
`ifdef CONTROL_STEP_EN
    test_step();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Eight-phase instruction sequencer for the VeriRISC CPU. It owns the fetch/decode/execute timing: it steps a 3-bit phase counter through a fixed instruction cycle and decodes phase, current opcode and the ALU `zero` flag into the control strobes for memory, instruction register, program counter and accumulator. It sits between the instruction register and the datapath (alu, accumulator, PC, memory). It is the only source of datapath load/enable strobes.

## Interface
Parameters: none (phase count and opcode encoding come from the shared package).

- `clk` in, 1: system clock; all state on posedge.
- `rst` in, 1: reset, synchronous, active-high.
- `opcode` in, `opcode_t`: current instruction from the instruction register; stable from OP_ADDR through STORE.
- `zero` in, 1: alu `zero` flag (accumulator == 0).
- `step` in, 1: single-step advance; present only with `CONTROL_STEP_EN`.
- `mem_rd` out, 1: memory read enable.
- `mem_wr` out, 1: memory write strobe.
- `load_ir` out, 1: load instruction register.
- `inc_pc` out, 1: increment program counter.
- `load_pc` out, 1: load PC from instruction address field.
- `load_ac` out, 1: load accumulator from alu `out`.
- `data_e` out, 1: drive accumulator onto data bus.
- `halt` out, 1: CPU halted.
- `phase` out, `phase_t`: current phase, for debug/bench.

## Operation
- Phases in order: INST_ADDR(0), INST_FETCH(1), INST_LOAD(2), IDLE(3), OP_ADDR(4), OP_FETCH(5), ALU_OP(6), STORE(7); STORE wraps to INST_ADDR. One phase per clock.
- ALUOP = opcode in {ADD, AND, XOR, LDA}.
- Strobe decode (combinational from `phase`, `opcode`, `zero`; all strobes 0 unless listed):
  - INST_ADDR: none.
  - INST_FETCH: `mem_rd`.
  - INST_LOAD, IDLE: `mem_rd`, `load_ir`.
  - OP_ADDR: `inc_pc` if opcode != HLT; `halt` if opcode == HLT.
  - OP_FETCH: `mem_rd` if ALUOP.
  - ALU_OP: `mem_rd`, `load_ac` if ALUOP; `inc_pc` if SKZ and `zero`; `load_pc` if JMP; `data_e` if STO.
  - STORE: `mem_rd`, `load_ac` if ALUOP; `load_pc` if JMP; `mem_wr`, `data_e` if STO.
- Halt: in OP_ADDR with opcode HLT, next phase = OP_ADDR (stall). `halt` stays 1, PC does not advance; only `rst` exits.
- `load_pc` and `inc_pc` never both 1 in the same cycle; `mem_rd` and `mem_wr` never both 1.

## Timing
- Reset: `rst` high at a posedge forces `phase` = INST_ADDR on that edge, overriding any phase, halt stall or step wait. All strobes and `halt` are 0 in INST_ADDR, so every output reads 0 from the first post-reset cycle.
- Free-running instruction latency: exactly 8 clocks; first fetch strobe (`mem_rd`) one clock after reset release.
- Strobes are valid for the whole phase. Datapath registers capture at the posedge that ends the phase. The alu evaluates on negedge within ALU_OP/STORE.
- `zero` is sampled combinationally during ALU_OP only. It reflects the accumulator before any load in that instruction.

## Configuration
- `CONTROL_STEP_EN` defined: `step` port exists. In INST_ADDR, phase advances to INST_FETCH only on a posedge with `step` = 1; otherwise it holds INST_ADDR with all strobes 0. Mid-instruction `step` is ignored; one `step` pulse executes exactly one instruction. Reset lands in the wait.
- Not defined: no `step` port; INST_ADDR always advances.

## Structure
- `typedefs` package: existing `opcode_t`; add `phase_t` (3-bit enum, values above) and a helper function `is_aluop(opcode_t)`.
- Single module with no sub-modules: one phase register plus a decode `always_comb`.

## Test plan
- Reset then LDA: phases 0..7 in 8 clocks; `mem_rd` high in phases 1,2,3,5,6,7; `load_ir` in 2,3; `inc_pc` in 4; `load_ac` in 6,7; wrap to 0.
- STO: `mem_wr` only in STORE; `data_e` in ALU_OP and STORE; `load_ac`, `mem_rd` 0 in phases 5–7.
- SKZ with `zero`=1: `inc_pc` in OP_ADDR and ALU_OP. With `zero`=0: OP_ADDR only.
- JMP: `load_pc` in ALU_OP and STORE; `inc_pc` 0 there.
- HLT: `phase` sticks at OP_ADDR with `halt`=1 and `inc_pc`=0 for ≥20 clocks. `rst` pulse returns to INST_ADDR with all outputs 0.
- `CONTROL_STEP_EN`: no `step` → holds INST_ADDR for 10 clocks. Single `step` pulse → exactly one 8-phase pass, then wait. `rst` asserted in ALU_OP → INST_ADDR next clock.
